// File: rtl/apb3_ms_pkg.sv
// Shared types and constants for the APB3 completer and its register bank.
package apb3_ms_pkg;

  // Completer FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACCESS = 2'd3
  } apb_state_e;

  // Default bus widths
  localparam int APB_DATA_W = 32;
  localparam int APB_ADDR_W = 32;
  localparam int APB_PROT_W = 3;

  // Register 0 is the read-only live status word
  localparam int REG0_IDX = 0;

  // Merge new data into an old word, byte lane b taken from new_v when strb[b]=1
  function automatic logic [APB_DATA_W-1:0] strb_merge(
    input logic [APB_DATA_W-1:0]   old_v,
    input logic [APB_DATA_W-1:0]   new_v,
    input logic [APB_DATA_W/8-1:0] strb
  );
    logic [APB_DATA_W-1:0] res;
    res = old_v;
    for (int b = 0; b < APB_DATA_W/8; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/apb3_ms_slave_if.sv
// APB3 bus segment between one requester and this completer.
interface apb3_ms_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8
);
  logic                  PSELx;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [STRB_WIDTH-1:0] PSTRB;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb3_ms_slv_regfile.sv
// Byte-strobed register bank: one write port, one combinational read port.
module apb3_ms_slv_regfile
  import apb3_ms_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int DATA_WIDTH = APB_DATA_W,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_widx,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [STRB_WIDTH-1:0] i_wstrb,
  input  logic [IDX_W-1:0]      i_ridx,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  // Storage: cleared by reset, lanes updated only where the strobe is set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regs <= '{default: '0};
    end else if (i_we) begin
      r_regs[i_widx] <= strb_merge(r_regs[i_widx], i_wdata, i_wstrb);
    end
  end

  assign o_rdata = r_regs[i_ridx];

endmodule

// File: rtl/apb3_ms_slave.sv
// APB3 completer: transfer FSM with programmable wait states, address
// decode with PSLVERR reporting, and a sticky protocol-violation flag.
module apb3_ms_slave
  import apb3_ms_pkg::*;
#(
  parameter int DATA_WIDTH = APB_DATA_W,
  parameter int ADDR_WIDTH = APB_ADDR_W,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int NUM_REGS   = 16,
  parameter int MAX_WAIT_W = 4
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  apb3_ms_slave_if.slave        bus,
  input  logic [MAX_WAIT_W-1:0] wait_cfg,
  input  logic [DATA_WIDTH-1:0] hw_status,
  output logic                  prot_err
);

  localparam int IDX_W = $clog2(NUM_REGS);

  apb_state_e            r_state;
  logic [MAX_WAIT_W-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_strb;
  logic                  r_err;
  logic                  r_pready;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_pslverr;
  logic                  r_prot_err;

  logic                  w_setup;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_write;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_reg_rdata;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_we;

  assign w_setup = bus.PSELx && !bus.PENABLE;

  // SETUP is the sampling edge of the bus setup phase, not a held state.
  // With wait_cfg=0 the ACCESS outputs are computed on that same edge, so
  // decode looks at the live bus then; from WAIT it uses the latched copy.
  always_comb begin
    if (r_state == ST_WAIT) begin
      w_addr  = r_addr;
      w_write = r_write;
    end else begin
      w_addr  = bus.PADDR;
      w_write = bus.PWRITE;
    end
  end

  assign w_idx = w_addr[2 +: IDX_W];

  // Decode: misaligned, out of range, or write to the read-only register 0
  always_comb begin
    w_err = 1'b0;
    if (w_addr[1:0] != 2'b00) begin
      w_err = 1'b1;
    end else if (|w_addr[ADDR_WIDTH-1:IDX_W+2]) begin
      w_err = 1'b1;
    end else if (w_write && (w_idx == IDX_W'(REG0_IDX))) begin
      w_err = 1'b1;
    end else begin
      w_err = 1'b0;
    end
  end

  // Read data presented in ACCESS; zero for errors and writes
  always_comb begin
    w_rdata = '0;
    if (w_err || w_write) begin
      w_rdata = '0;
    end else if (w_idx == IDX_W'(REG0_IDX)) begin
      w_rdata = hw_status;
    end else begin
      w_rdata = w_reg_rdata;
    end
  end

  // Writes commit on the edge that ends the ACCESS cycle
  assign w_we = (r_state == ST_ACCESS) && r_write && !r_err;

  apb3_ms_slv_regfile #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .clk     (PCLK),
    .rst     (PRESET),
    .i_we    (w_we),
    .i_widx  (r_addr[2 +: IDX_W]),
    .i_wdata (r_wdata),
    .i_wstrb (r_strb),
    .i_ridx  (w_idx),
    .o_rdata (w_reg_rdata)
  );

  // Transfer FSM with registered completion outputs (zero outside ACCESS)
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_strb     <= '0;
      r_err      <= 1'b0;
      r_pready   <= 1'b0;
      r_prdata   <= '0;
      r_pslverr  <= 1'b0;
      r_prot_err <= 1'b0;
    end else begin
      r_pready  <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
      case (r_state)
        ST_IDLE, ST_ACCESS: begin
          if ((r_state == ST_IDLE) && bus.PSELx && bus.PENABLE) begin
            r_prot_err <= 1'b1;
          end else if (w_setup) begin
            r_addr  <= bus.PADDR;
            r_write <= bus.PWRITE;
            r_wdata <= bus.PWDATA;
            r_strb  <= bus.PSTRB;
            r_cnt   <= wait_cfg;
            if (wait_cfg == '0) begin
              r_state   <= ST_ACCESS;
              r_pready  <= 1'b1;
              r_prdata  <= w_rdata;
              r_pslverr <= w_err;
              r_err     <= w_err;
            end else begin
              r_state <= ST_WAIT;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!bus.PSELx) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == MAX_WAIT_W'(1)) begin
            r_cnt     <= '0;
            r_state   <= ST_ACCESS;
            r_pready  <= 1'b1;
            r_prdata  <= w_rdata;
            r_pslverr <= w_err;
            r_err     <= w_err;
          end else begin
            r_cnt <= r_cnt - MAX_WAIT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.PREADY  = r_pready;
  assign bus.PRDATA  = r_prdata;
  assign bus.PSLVERR = r_pslverr;
  assign prot_err    = r_prot_err;

endmodule

// File: tb/tb_apb3_ms_slave.sv
// Directed bench for apb3_ms_slave: transfers, latency, decode errors,
// abort, reset mid-transfer and the sticky protocol flag.
module tb_apb3_ms_slave;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [3:0]  wait_cfg;
  logic [31:0] hw_status;
  logic        prot_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rd;
  logic        er;
  int          cyc;
  logic        seen;

  apb3_ms_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  always #5 PCLK = ~PCLK;

  apb3_ms_slave #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .NUM_REGS   (16),
    .MAX_WAIT_W (4)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .bus       (bus),
    .wait_cfg  (wait_cfg),
    .hw_status (hw_status),
    .prot_err  (prot_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transfer; returns data, error and cycles from SETUP to PREADY
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, output logic [31:0] rdata,
                      output logic err, output int n);
    @(posedge PCLK); #1;
    bus.PSELx   = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = addr;
    bus.PWDATA  = wdata;
    bus.PSTRB   = strb;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    n = 1;
    while (bus.PREADY !== 1'b1 && n < 40) begin
      @(posedge PCLK); #1;
      n++;
    end
    rdata = bus.PRDATA;
    err   = bus.PSLVERR;
  endtask

  // Release the bus after ACCESS; PREADY must already be low again
  task automatic idle(input string tag);
    @(posedge PCLK); #1;
    bus.PSELx   = 1'b0;
    bus.PENABLE = 1'b0;
    chk(tag, {31'd0, bus.PREADY}, 32'd0);
  endtask

  initial begin
    PRESET      = 1'b1;
    wait_cfg    = 4'd0;
    hw_status   = 32'h0;
    bus.PSELx   = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = 32'h0;
    bus.PWDATA  = 32'h0;
    bus.PSTRB   = 4'h0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_pready",   {31'd0, bus.PREADY},  32'd0);
    chk("rst_prdata",   bus.PRDATA,           32'd0);
    chk("rst_pslverr",  {31'd0, bus.PSLVERR}, 32'd0);
    chk("rst_prot_err", {31'd0, prot_err},    32'd0);
    PRESET = 1'b0;

    // Zero-wait write then read
    xfer(1'b1, 32'h04, 32'hDEADBEEF, 4'hF, rd, er, cyc);
    chk("w04_cyc", cyc, 32'd1);
    chk("w04_err", {31'd0, er}, 32'd0);
    idle("w04_pready_one");
    xfer(1'b0, 32'h04, 32'h0, 4'h0, rd, er, cyc);
    chk("r04_cyc", cyc, 32'd1);
    chk("r04_data", rd, 32'hDEADBEEF);
    chk("r04_err", {31'd0, er}, 32'd0);
    idle("r04_pready_one");

    // Three wait states, partial strobe
    wait_cfg = 4'd3;
    xfer(1'b1, 32'h08, 32'h11223344, 4'h5, rd, er, cyc);
    chk("w08_cyc", cyc, 32'd4);
    chk("w08_err", {31'd0, er}, 32'd0);
    idle("w08_pready_one");
    xfer(1'b0, 32'h08, 32'h0, 4'h0, rd, er, cyc);
    chk("r08_cyc", cyc, 32'd4);
    chk("r08_data", rd, 32'h00220044);
    idle("r08_pready_one");
    wait_cfg = 4'd0;

    // Decode errors
    xfer(1'b0, 32'h40, 32'h0, 4'h0, rd, er, cyc);
    chk("r40_err", {31'd0, er}, 32'd1);
    chk("r40_data", rd, 32'd0);
    idle("r40_idle");
    xfer(1'b1, 32'h06, 32'hFFFFFFFF, 4'hF, rd, er, cyc);
    chk("w06_err", {31'd0, er}, 32'd1);
    chk("w06_data", rd, 32'd0);
    idle("w06_idle");
    xfer(1'b1, 32'h00, 32'h12345678, 4'hF, rd, er, cyc);
    chk("w00_err", {31'd0, er}, 32'd1);
    chk("w00_data", rd, 32'd0);
    idle("w00_idle");
    xfer(1'b0, 32'h04, 32'h0, 4'h0, rd, er, cyc);
    chk("r04_after_err", rd, 32'hDEADBEEF);
    idle("r04b_idle");
    xfer(1'b0, 32'h08, 32'h0, 4'h0, rd, er, cyc);
    chk("r08_after_err", rd, 32'h00220044);
    idle("r08b_idle");

    // Zero strobe write leaves the register alone
    xfer(1'b1, 32'h04, 32'h0, 4'h0, rd, er, cyc);
    chk("wstrb0_err", {31'd0, er}, 32'd0);
    idle("wstrb0_idle");
    xfer(1'b0, 32'h04, 32'h0, 4'h0, rd, er, cyc);
    chk("r04_strb0", rd, 32'hDEADBEEF);
    idle("r04c_idle");

    // Live status at register 0
    hw_status = 32'hA5A5_0001;
    xfer(1'b0, 32'h00, 32'h0, 4'h0, rd, er, cyc);
    chk("r00_data", rd, 32'hA5A50001);
    chk("r00_err", {31'd0, er}, 32'd0);
    idle("r00_idle");

    // Abort by dropping PSELx in the second wait cycle
    wait_cfg = 4'd4;
    @(posedge PCLK); #1;
    bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 32'h0C; bus.PWDATA = 32'hCAFEF00D; bus.PSTRB = 4'hF;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    bus.PSELx = 1'b0; bus.PENABLE = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge PCLK); #1;
      if (bus.PREADY === 1'b1) seen = 1'b1;
    end
    chk("abort_no_pready", {31'd0, seen}, 32'd0);
    wait_cfg = 4'd0;
    xfer(1'b0, 32'h0C, 32'h0, 4'h0, rd, er, cyc);
    chk("abort_no_write", rd, 32'd0);
    idle("abort_idle");

    // Reset asserted mid-WAIT
    wait_cfg = 4'd4;
    @(posedge PCLK); #1;
    bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 32'h10; bus.PWDATA = 32'h55AA55AA; bus.PSTRB = 4'hF;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    bus.PSELx = 1'b0; bus.PENABLE = 1'b0;
    #1;
    chk("rst_mid_pready", {31'd0, bus.PREADY}, 32'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge PCLK); #1;
      if (bus.PREADY === 1'b1) seen = 1'b1;
    end
    chk("rst_mid_no_pready", {31'd0, seen}, 32'd0);
    wait_cfg  = 4'd0;
    hw_status = 32'h0;
    xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, cyc);
    chk("rst_r10", rd, 32'd0);
    idle("rst_r10_idle");
    xfer(1'b0, 32'h04, 32'h0, 4'h0, rd, er, cyc);
    chk("rst_r04", rd, 32'd0);
    idle("rst_r04_idle");
    xfer(1'b0, 32'h08, 32'h0, 4'h0, rd, er, cyc);
    chk("rst_r08", rd, 32'd0);
    idle("rst_r08_idle");
    xfer(1'b0, 32'h00, 32'h0, 4'h0, rd, er, cyc);
    chk("rst_r00", rd, 32'd0);
    idle("rst_r00_idle");
    chk("prot_err_clean", {31'd0, prot_err}, 32'd0);

    // Protocol violation from IDLE is sticky until reset
    @(posedge PCLK); #1;
    bus.PSELx = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = 32'h04;
    @(posedge PCLK); #1;
    bus.PSELx = 1'b0; bus.PENABLE = 1'b0;
    chk("prot_err_set", {31'd0, prot_err}, 32'd1);
    xfer(1'b1, 32'h14, 32'h01020304, 4'hF, rd, er, cyc);
    chk("prot_w14_err", {31'd0, er}, 32'd0);
    idle("prot_w14_idle");
    xfer(1'b0, 32'h14, 32'h0, 4'h0, rd, er, cyc);
    chk("prot_r14_data", rd, 32'h01020304);
    idle("prot_r14_idle");
    chk("prot_err_sticky", {31'd0, prot_err}, 32'd1);
    PRESET = 1'b1;
    #1;
    chk("prot_err_cleared", {31'd0, prot_err}, 32'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
